// File: rtl/mul4_ctrl.sv
// mul4_ctrl: sequential 4x4 unsigned shift-and-add multiplier controller.
//
// One operand pair is accepted on a start pulse while idle. A single 4-bit
// ripple adder (sum4) is then stepped through one partial-product
// accumulation per clock. The 8-bit product is registered and announced by
// a one-cycle done strobe.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-high reset
//   start  in   1  request, sampled only while idle
//   a      in   4  multiplicand (unsigned), latched on accepted start
//   b      in   4  multiplier (unsigned), latched on accepted start
//   busy   out  1  high whenever the controller is not idle
//   done   out  1  one-cycle strobe, p valid from this cycle
//   p      out  8  registered product, held until next completion or reset
//
// Build option:
//   MUL4_SKIP_ZERO_EN  when defined, finish early once the remaining
//                      multiplier bits are all zero. Products are identical
//                      in both builds; only latency changes.

// 4-bit ripple-carry adder shared by the multiplier datapath.
module sum4 (
    output logic [3:0] s,
    output logic       cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);
    logic [4:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];
endmodule

module mul4_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAdd  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] mplier_q, mplier_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] count_q, count_d;
    logic [7:0] p_q, p_d;
    logic       done_q, done_d;

    logic [3:0] add_s;
    logic       add_cout;
    logic [8:0] acc_pre;   // accumulator before the right shift, carry in bit 8
    logic [7:0] acc_step;  // accumulator after one shift-and-add iteration
    logic [2:0] count_inc;

    sum4 u_sum4 (
        .s    (add_s),
        .cout (add_cout),
        .a    (acc_q[7:4]),
        .b    (mcand_q),
        .cin  (1'b0)
    );

    // The adder carry lands in the top bit before shifting, so the
    // accumulator can never overflow.
    always_comb begin
        if (mplier_q[0]) begin
            acc_pre = {add_cout, add_s, acc_q[3:0]};
        end else begin
            acc_pre = {1'b0, acc_q[7:4], acc_q[3:0]};
        end
        acc_step  = acc_pre[8:1];
        count_inc = count_q + 3'd1;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        p_d      = p_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = 8'h00;
                    count_d  = 3'd0;
                    state_d  = StAdd;
                end
            end
            StAdd: begin
`ifdef MUL4_SKIP_ZERO_EN
                if (mplier_q == 4'd0) begin
                    // After k iterations the accumulator holds the product
                    // scaled up by 2^(4-k); undo that scaling here.
                    p_d     = acc_q >> (3'd4 - count_q);
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    acc_d    = acc_step;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_inc;
                    if (count_inc == 3'd4) begin
                        p_d     = acc_step;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
`else
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                count_d  = count_inc;
                if (count_inc == 3'd4) begin
                    p_d     = acc_step;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= 4'h0;
            mplier_q <= 4'h0;
            acc_q    <= 8'h00;
            count_q  <= 3'd0;
            p_q      <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign p    = p_q;
endmodule

// File: tb/tb_mul4_ctrl.sv
// Self-checking bench for mul4_ctrl: fixed vector table, hand-written
// corner sequences (reset with start, start during an operation, reset
// mid-operation) and randomized operands against an arithmetic model.
module tb_mul4_ctrl;
    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int checks;
    int failures;

`ifdef MUL4_SKIP_ZERO_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         p;
        int         lat_skip;  // latency when early finish is enabled
    } vec_t;

    vec_t vecs[10];

    mul4_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Latency in cycles from the accepting edge to the done cycle.
    function automatic int lat_model(input logic [3:0] bb);
        int hb;
        if (!Skip) return 4;
        if (bb == 4'd0) return 1;
        hb = 0;
        for (int i = 0; i < 4; i++) begin
            if (bb[i]) hb = i;
        end
        return (hb + 2 > 4) ? 4 : hb + 2;
    endfunction

    // Called at posedge+1 with the DUT idle. Returns at posedge+1, idle.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input int exp_p,
                          input int exp_lat, input string name);
        int  n;
        int  busy_cnt;
        bit  seen;
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        busy_cnt = int'(busy);
        seen     = 1'b0;
        n        = -1;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                n    = k;
            end
        end
        chk({name, ".latency"}, n, exp_lat);
        chk({name, ".p"}, int'(p), exp_p);
        chk({name, ".busy_cycles"}, busy_cnt, exp_lat + 1);
        @(posedge clk);
        #1;
        chk({name, ".idle_after"}, int'({busy, done}), 0);
        chk({name, ".p_hold"}, int'(p), exp_p);
    endtask

    initial begin
        int n;
        bit seen;
        int dcount;
        logic [3:0] ra, rb;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b1;
        a        = 4'hF;
        b        = 4'hF;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 15,  lat_skip: 4};
        vecs[1] = '{a: 4'hF,  b: 4'hF,  p: 225, lat_skip: 4};
        vecs[2] = '{a: 4'd0,  b: 4'hF,  p: 0,   lat_skip: 4};
        vecs[3] = '{a: 4'd2,  b: 4'd7,  p: 14,  lat_skip: 4};
        vecs[4] = '{a: 4'd9,  b: 4'd1,  p: 9,   lat_skip: 2};
        vecs[5] = '{a: 4'd9,  b: 4'd8,  p: 72,  lat_skip: 4};
        vecs[6] = '{a: 4'd0,  b: 4'd0,  p: 0,   lat_skip: 1};
        vecs[7] = '{a: 4'd5,  b: 4'd2,  p: 10,  lat_skip: 3};
        vecs[8] = '{a: 4'hF,  b: 4'd0,  p: 0,   lat_skip: 1};
        vecs[9] = '{a: 4'd1,  b: 4'd3,  p: 3,   lat_skip: 3};

        // Reset held together with start: must stay idle, no done.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("reset_start.busy", int'(busy), 0);
            chk("reset_start.done", int'(done), 0);
            chk("reset_start.p", int'(p), 0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset.busy", int'(busy), 0);

        // Fixed vectors.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, Skip ? vecs[i].lat_skip : 4,
                   $sformatf("vec%0d", i));
        end

        // Start pulsed during an operation with new operands: ignored.
        a     = 4'd3;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a     = 4'd7;
        b     = 4'd7;
        start = 1'b1;
        seen  = 1'b0;
        n     = -1;
        for (int k = 2; k <= 8 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
                n    = k - 1;
            end else begin
                @(posedge clk);
                #1;
                if (done) begin
                    seen = 1'b1;
                    n    = k;
                end
            end
        end
        start = 1'b0;
        chk("midstart.latency", n, 4);
        chk("midstart.p", int'(p), 15);
        @(posedge clk);
        #1;
        chk("midstart.not_accepted", int'({busy, done}), 0);
        run_op(4'd7, 4'd7, 49, lat_model(4'd7), "after_midstart");

        // Reset asserted at the second ADD edge: abort without done.
        a     = 4'd3;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.p", int'(p), 0);
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcount++;
        end
        chk("abort.quiet", dcount, 0);
        run_op(4'd2, 4'd7, 14, lat_model(4'd7), "after_abort");

        // Randomized operands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            run_op(ra, rb, int'(ra) * int'(rb), lat_model(rb),
                   $sformatf("rand%0d_%0dx%0d", i, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
